// File: rtl/muldiv_hilo_unit.sv
// Iterative MIPS mul/div sequencer with architectural HI/LO and hazard stall.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    input  logic             i_mthi,
    input  logic             i_mtlo,
    input  logic             i_hilo_read,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_stall
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t r_state, w_next;

    logic [WIDTH-1:0]   r_hi, r_lo;
    logic [WIDTH-1:0]   r_a, r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_mul, r_qsign, r_rsign, r_dz;

    logic               w_op_valid, w_is_mul, w_is_signed;
    logic               w_go, w_go_slow, w_dz;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_sum, w_rem_sh;
    logic [WIDTH-1:0]   w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_res;

    assign w_op_valid  = (i_op[3:2] == 2'b10);
    assign w_is_mul    = i_op[1];
    assign w_is_signed = ~i_op[0];
    assign w_go        = (r_state == S_IDLE) & i_start & w_op_valid & ~i_flush;
    assign w_dz        = ~w_is_mul & (i_src_b == '0);

    assign w_abs_a = (w_is_signed && i_src_a[WIDTH-1]) ? -i_src_a : i_src_a;
    assign w_abs_b = (w_is_signed && i_src_b[WIDTH-1]) ? -i_src_b : i_src_b;

`ifdef MULDIV_FAST_MUL_EN
    logic                      w_go_fast;
    logic signed [2*WIDTH-1:0] w_fast_s;
    logic [2*WIDTH-1:0]        w_fast;

    assign w_fast_s  = $signed(i_src_a) * $signed(i_src_b);
    assign w_fast    = w_is_signed ? w_fast_s : i_src_a * i_src_b;
    assign w_go_fast = w_go & w_is_mul;
    assign w_go_slow = w_go & ~w_is_mul;
`else
    assign w_go_slow = w_go;
`endif

    // Shift-add step: add multiplicand into the upper half, then shift right.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
    assign w_mul_next = r_b[0] ? {w_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

    // Restoring step: the shifted remainder needs one extra bit.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge       = (w_rem_sh >= {1'b0, r_b});
    assign w_diff     = w_rem_sh[WIDTH-1:0] - r_b;
    assign w_div_next = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                             : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    always_comb begin
        w_res = r_acc;
        if (r_mul) begin
            if (r_qsign) w_res = -r_acc;
        end else if (!r_dz) begin
            w_res[2*WIDTH-1:WIDTH] = r_rsign ? -r_acc[2*WIDTH-1:WIDTH]
                                             : r_acc[2*WIDTH-1:WIDTH];
            w_res[WIDTH-1:0]       = r_qsign ? -r_acc[WIDTH-1:0]
                                             : r_acc[WIDTH-1:0];
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_go_slow) w_next = w_dz ? S_FIX : S_RUN;
            S_RUN:  if (r_cnt == '0) w_next = S_FIX;
            S_FIX:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_flush) w_next = S_IDLE;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_mul   <= 1'b0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
            r_dz    <= 1'b0;
        end else if (w_go_slow) begin
            r_a     <= w_abs_a;
            r_b     <= w_abs_b;
            r_cnt   <= CW'(WIDTH - 1);
            r_mul   <= w_is_mul;
            r_qsign <= w_is_signed & (i_src_a[WIDTH-1] ^ i_src_b[WIDTH-1]);
            r_rsign <= w_is_signed & i_src_a[WIDTH-1];
            r_dz    <= w_dz;
            // Divide-by-zero result is staged directly for FIX.
            if (w_dz)          r_acc <= {i_src_a, {WIDTH{1'b1}}};
            else if (w_is_mul) r_acc <= '0;
            else               r_acc <= {{WIDTH{1'b0}}, w_abs_a};
        end else if (r_state == S_RUN) begin
            r_acc <= r_mul ? w_mul_next : w_div_next;
            r_b   <= r_mul ? (r_b >> 1) : r_b;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (!i_flush) begin
            if (r_state == S_FIX) begin
                r_hi <= w_res[2*WIDTH-1:WIDTH];
                r_lo <= w_res[WIDTH-1:0];
            end else if (r_state == S_IDLE && !w_go) begin
                if (i_mthi) r_hi <= i_src_a;
                if (i_mtlo) r_lo <= i_src_a;
            end
`ifdef MULDIV_FAST_MUL_EN
            if (w_go_fast) begin
                r_hi <= w_fast[2*WIDTH-1:WIDTH];
                r_lo <= w_fast[WIDTH-1:0];
            end
`endif
        end
    end

    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
    assign o_busy  = (r_state != S_IDLE);
    assign o_stall = o_busy & (i_start | i_mthi | i_mtlo | i_hilo_read);

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed self-checking bench for muldiv_hilo_unit.
// Honors MULDIV_FAST_MUL_EN for multiply timing expectations.
module tb_muldiv_hilo_unit;
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [3:0]  i_op;
    logic [31:0] i_src_a, i_src_b;
    logic        i_mthi, i_mtlo, i_hilo_read, i_flush;
    logic [31:0] o_hi, o_lo;
    logic        o_busy, o_stall;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [3:0] OP_DIV   = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_MULT  = 4'b1010;
    localparam logic [3:0] OP_MULTU = 4'b1011;

`ifdef MULDIV_FAST_MUL_EN
    localparam int         MUL_BUSY = 0;
    localparam logic [3:0] FLUSH_OP = OP_DIV;
`else
    localparam int         MUL_BUSY = 33;
    localparam logic [3:0] FLUSH_OP = OP_MULT;
`endif

    muldiv_hilo_unit #(.WIDTH(32)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
        .i_src_a(i_src_a), .i_src_b(i_src_b), .i_mthi(i_mthi),
        .i_mtlo(i_mtlo), .i_hilo_read(i_hilo_read), .i_flush(i_flush),
        .o_hi(o_hi), .o_lo(o_lo), .o_busy(o_busy), .o_stall(o_stall)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int nb);
        i_op = op; i_src_a = a; i_src_b = b; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        nb = 0;
        while (o_busy && nb < 100) begin
            nb++;
            tick();
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_start = 0; i_op = 0; i_src_a = 0; i_src_b = 0;
        i_mthi = 0; i_mtlo = 0; i_hilo_read = 0; i_flush = 0;
        tick(); tick();
        n_tests++; if (o_hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", o_hi); end
        n_tests++; if (o_lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", o_lo); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_tests++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", o_stall); end
        i_reset = 1'b0;
        tick();
    endtask

    task automatic test_mthi_mtlo();
        i_src_a = 32'h1234; i_mthi = 1; tick(); i_mthi = 0;
        n_tests++; if (o_hi !== 32'h1234) begin n_fail++; $display("FAIL mthi_hi: got %h want 00001234", o_hi); end
        n_tests++; if (o_lo !== 32'h0) begin n_fail++; $display("FAIL mthi_lo: got %h want 0", o_lo); end
        i_src_a = 32'h5678; i_mtlo = 1; tick(); i_mtlo = 0;
        n_tests++; if (o_lo !== 32'h5678) begin n_fail++; $display("FAIL mtlo_lo: got %h want 00005678", o_lo); end
        n_tests++; if (o_hi !== 32'h1234) begin n_fail++; $display("FAIL mtlo_hi: got %h want 00001234", o_hi); end
        i_src_a = 32'h9999; i_mthi = 1; i_mtlo = 1; tick(); i_mthi = 0; i_mtlo = 0;
        n_tests++; if (o_hi !== 32'h9999 || o_lo !== 32'h9999) begin
            n_fail++; $display("FAIL mthilo_both: got %h/%h want 00009999/00009999", o_hi, o_lo); end
        // start with mthi: the write must be dropped
        i_op = OP_DIVU; i_src_a = 32'd9; i_src_b = 32'd3; i_start = 1; i_mthi = 1;
        tick();
        i_start = 0; i_mthi = 0;
        n_tests++; if (o_hi !== 32'h9999) begin n_fail++; $display("FAIL start_wins_hi: got %h want 00009999", o_hi); end
        n_tests++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL start_wins_busy: got %b want 1", o_busy); end
        for (int g = 0; g < 100 && o_busy; g++) tick();
        n_tests++; if (o_hi !== 32'd0 || o_lo !== 32'd3) begin
            n_fail++; $display("FAIL start_wins_res: got %h/%h want 00000000/00000003", o_hi, o_lo); end
    endtask

    task automatic test_mul();
        int nb;
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, nb);
        n_tests++; if (nb !== MUL_BUSY) begin n_fail++; $display("FAIL multu_busy: got %0d want %0d", nb, MUL_BUSY); end
        n_tests++; if (o_hi !== 32'hFFFFFFFE || o_lo !== 32'h1) begin
            n_fail++; $display("FAIL multu_max: got %h/%h want fffffffe/00000001", o_hi, o_lo); end
        run_op(OP_MULT, 32'hFFFFFFFF, 32'h1, nb);
        n_tests++; if (o_hi !== 32'hFFFFFFFF || o_lo !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL mult_m1x1: got %h/%h want ffffffff/ffffffff", o_hi, o_lo); end
        run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, nb);
        n_tests++; if (o_hi !== 32'hFFFFFFFF || o_lo !== 32'hFFFFFFEB) begin
            n_fail++; $display("FAIL mult_m3x7: got %h/%h want ffffffff/ffffffeb", o_hi, o_lo); end
        run_op(OP_MULTU, 32'h00012345, 32'h00010000, nb);
        n_tests++; if (o_hi !== 32'h00000001 || o_lo !== 32'h23450000) begin
            n_fail++; $display("FAIL multu_shift: got %h/%h want 00000001/23450000", o_hi, o_lo); end
    endtask

    task automatic test_div();
        int nb;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, nb);
        n_tests++; if (nb !== 33) begin n_fail++; $display("FAIL div_busy: got %0d want 33", nb); end
        n_tests++; if (o_hi !== 32'hFFFFFFFF || o_lo !== 32'hFFFFFFFD) begin
            n_fail++; $display("FAIL div_m7d2: got %h/%h want ffffffff/fffffffd", o_hi, o_lo); end
        run_op(OP_DIVU, 32'd100, 32'd7, nb);
        n_tests++; if (o_hi !== 32'd2 || o_lo !== 32'd14) begin
            n_fail++; $display("FAIL divu_100d7: got %h/%h want 00000002/0000000e", o_hi, o_lo); end
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, nb);
        n_tests++; if (o_hi !== 32'h0 || o_lo !== 32'h80000000) begin
            n_fail++; $display("FAIL div_ovf: got %h/%h want 00000000/80000000", o_hi, o_lo); end
        run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, nb);
        n_tests++; if (o_hi !== 32'd1 || o_lo !== 32'hFFFFFFFD) begin
            n_fail++; $display("FAIL div_7dm2: got %h/%h want 00000001/fffffffd", o_hi, o_lo); end
        run_op(OP_DIVU, 32'hFFFFFFFF, 32'h00010000, nb);
        n_tests++; if (o_hi !== 32'h0000FFFF || o_lo !== 32'h0000FFFF) begin
            n_fail++; $display("FAIL divu_big: got %h/%h want 0000ffff/0000ffff", o_hi, o_lo); end
    endtask

    task automatic test_div_zero();
        int nb;
        run_op(OP_DIVU, 32'd5, 32'd0, nb);
        n_tests++; if (nb !== 1) begin n_fail++; $display("FAIL divz_busy: got %0d want 1", nb); end
        n_tests++; if (o_hi !== 32'd5 || o_lo !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL divu_z: got %h/%h want 00000005/ffffffff", o_hi, o_lo); end
        run_op(OP_DIV, 32'hFFFFFFFC, 32'd0, nb);
        n_tests++; if (o_hi !== 32'hFFFFFFFC || o_lo !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL div_z: got %h/%h want fffffffc/ffffffff", o_hi, o_lo); end
    endtask

    task automatic test_stall();
        int g;
        i_op = OP_DIVU; i_src_a = 32'd100; i_src_b = 32'd7; i_start = 1;
        tick();
        i_start = 0;
        repeat (4) tick();
        i_hilo_read = 1; i_mthi = 1; i_src_a = 32'hDEAD;
        #1;
        g = 0;
        while (o_busy && g < 64) begin
            n_tests++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b want 1 at %0d", o_stall, g); end
            g++;
            tick();
        end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL stall_timeout: busy %b want 0", o_busy); end
        n_tests++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b want 0", o_stall); end
        n_tests++; if (o_hi !== 32'd2 || o_lo !== 32'd14) begin
            n_fail++; $display("FAIL stall_result: got %h/%h want 00000002/0000000e", o_hi, o_lo); end
        i_hilo_read = 0; i_mthi = 0;
        tick();
    endtask

    task automatic test_flush();
        int nb;
        i_src_a = 32'hAAAA; i_mthi = 1; tick(); i_mthi = 0;
        i_src_a = 32'h5555; i_mtlo = 1; tick(); i_mtlo = 0;
        i_op = FLUSH_OP; i_src_a = 32'd12345; i_src_b = 32'd678; i_start = 1;
        tick();
        i_start = 0;
        repeat (10) tick();
        i_flush = 1; tick(); i_flush = 0;
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", o_busy); end
        n_tests++; if (o_hi !== 32'hAAAA || o_lo !== 32'h5555) begin
            n_fail++; $display("FAIL flush_hilo: got %h/%h want 0000aaaa/00005555", o_hi, o_lo); end
        run_op(OP_DIVU, 32'd100, 32'd7, nb);
        n_tests++; if (nb !== 33) begin n_fail++; $display("FAIL flush_next_busy: got %0d want 33", nb); end
        n_tests++; if (o_hi !== 32'd2 || o_lo !== 32'd14) begin
            n_fail++; $display("FAIL flush_next_res: got %h/%h want 00000002/0000000e", o_hi, o_lo); end
    endtask

    task automatic test_bad_op();
        i_src_a = 32'hAAAA; i_mthi = 1; tick(); i_mthi = 0;
        i_src_a = 32'h5555; i_mtlo = 1; tick(); i_mtlo = 0;
        i_op = 4'b0010; i_src_a = 32'd3; i_src_b = 32'd4; i_start = 1;
        tick();
        i_start = 0;
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL badop_busy: got %b want 0", o_busy); end
        n_tests++; if (o_hi !== 32'hAAAA || o_lo !== 32'h5555) begin
            n_fail++; $display("FAIL badop_hilo: got %h/%h want 0000aaaa/00005555", o_hi, o_lo); end
    endtask

    task automatic test_async_reset();
        i_op = OP_DIV; i_src_a = 32'd1000; i_src_b = 32'd3; i_start = 1;
        tick();
        i_start = 0;
        repeat (9) tick();
        n_tests++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL areset_pre_busy: got %b want 1", o_busy); end
        #2 i_reset = 1;
        #1;
        n_tests++; if (o_hi !== 32'h0 || o_lo !== 32'h0) begin
            n_fail++; $display("FAIL areset_hilo: got %h/%h want 0/0", o_hi, o_lo); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b want 0", o_busy); end
        #1 i_reset = 0;
        tick();
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL areset_after: got %b want 0", o_busy); end
    endtask

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_mul();
        test_div();
        test_div_zero();
        test_stall();
        test_flush();
        test_bad_op();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
